shared_reg_arbiter: RTL

Round-robin arbiter that shares a single W-bit D-type storage register among N requesters. It grants ownership one requester at a time, loads the owner's write data into the register every owned cycle, and optionally holds ownership under a lock with a bounded hold time. It sits between the requesting datapath blocks and the shared clear-able flip-flop bank, and is the only writer of that bank.

---
 rtl/shared_reg_arb_pkg.sv | 36 +++
 rtl/rr_picker.sv | 23 ++
 rtl/shared_reg_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and the rotating-priority pick used by the shared register arbiter.
// Latency: combinational helper. Backpressure: none.
package shared_reg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int MAX_N = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of req scanning upward from ptr, wrapping within n entries.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input logic [2:0]       ptr,
                                      input int               n);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (!res.found && req[j[2:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[2:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority encoder: first active request at or after ptr.
// Latency: combinational. Backpressure: none.
module rr_picker
    import shared_reg_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    pick_t res;

    always_comb begin
        res   = rr_pick(MAX_N'(req), 3'(ptr), N);
        found = res.found;
        idx   = res.idx[IW-1:0];
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of a single shared W-bit register with bounded lock hold.
// Latency: grant, owner and q register one edge after req. Backpressure: req held until gnt.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int W        = 8,
    parameter  int MAX_HOLD = 8,
    localparam int OW       = (N > 1) ? $clog2(N) : 1,
    localparam int HW       = $clog2(MAX_HOLD) + 1
) (
    input  logic           clk,
    input  logic           clear_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [OW-1:0]  owner,
    output logic           owner_valid,
    output logic [W-1:0]   q,
    output logic [HW-1:0]  hold_cnt
);

    state_t        state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] nxt_owner;
    logic [OW-1:0] start;
    logic          cont;
    logic          pk_found;
    logic [OW-1:0] pk_idx;
    logic [W-1:0]  pk_data;
    logic [W-1:0]  own_data;

    assign owner_valid = (state == OWNED);

    always_comb begin
        nxt_owner = (owner == OW'(N-1)) ? '0 : owner + 1'b1;
        // After a release the search begins just past the outgoing owner.
        start     = (state == OWNED) ? nxt_owner : ptr;
        cont      = (state == OWNED) && req[owner] && lock[owner]
                    && (hold_cnt < HW'(MAX_HOLD-1));
        pk_data   = wdata[int'(pk_idx)*W +: W];
        own_data  = wdata[int'(owner)*W +: W];
    end

    rr_picker #(.N(N)) u_picker (
        .req   (req),
        .ptr   (start),
        .found (pk_found),
        .idx   (pk_idx)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            q        <= '0;
            hold_cnt <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pk_found) begin
                        state    <= OWNED;
                        gnt      <= N'(1) << pk_idx;
                        owner    <= pk_idx;
                        q        <= pk_data;
                        hold_cnt <= '0;
                    end
                end
                OWNED: begin
                    if (cont) begin
                        q        <= own_data;
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        ptr <= nxt_owner;
                        if (pk_found) begin
                            gnt      <= N'(1) << pk_idx;
                            owner    <= pk_idx;
                            q        <= pk_data;
                            hold_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            owner    <= '0;
                            hold_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
